// File: rtl/mips_pkg.sv
// Shared fetch-FSM state encoding and fault codes for the instruction fetch path.
// Pure declarations: no latency, no flow control.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_PROG  = 2'd2
  } fetch_state_t;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  // Both faults together give 2'b11.
  function automatic logic [1:0] fault_code(input logic misaligned, input logic out_of_range);
    return (misaligned ? FAULT_MISALIGN : FAULT_NONE) | (out_of_range ? FAULT_RANGE : FAULT_NONE);
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: one synchronous write port, one registered read port.
// Read data appears one cycle after rd_en and is held until the next rd_en.
module inst_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage has no reset so programmed words survive a reset pulse.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/inst_mem_fetch.sv
// Instruction fetch with programming mode: one-cycle fetch latency, fault tagging, fetch counter.
// fetch_ready drops while a result is stalled (inst_ready low) and outside RUN; results hold while stalled.
module inst_mem_fetch
  import mips_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 128,
  parameter int              ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     prog_en,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [DATA_W-1:0]        prog_data,
  input  logic                     fetch_req,
  input  logic [ADDR_W-1:0]        fetch_addr,
  output logic                     fetch_ready,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [DATA_W-1:0]        inst,
  output logic [1:0]               inst_fault,
  output logic [15:0]              fetch_count
);

  localparam int AW         = $clog2(DEPTH);
  localparam int BYTE_SHIFT = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] LSB_MASK  = ADDR_W'((1 << BYTE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic              out_free;
  logic              accept;
  logic              mem_we;
  logic [ADDR_W-1:0] word_index;
  logic              misaligned;
  logic              out_of_range;
  logic [DATA_W-1:0] rd_data;

  assign out_free     = !inst_valid || inst_ready;
  assign fetch_ready  = reset_n && (state == ST_RUN) && out_free;
  assign accept       = fetch_ready && fetch_req;
  assign mem_we       = (state == ST_PROG) && prog_we;
  assign word_index   = fetch_addr >> BYTE_SHIFT;
  assign misaligned   = |(fetch_addr & LSB_MASK);
  assign out_of_range = word_index >= DEPTH_LIM;

  // A fetch accepted in the same cycle as prog_en leaves a result behind, so that case drains first.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (prog_en) state_nxt = (out_free && !accept) ? ST_PROG : ST_DRAIN;
      ST_DRAIN: if (!prog_en) state_nxt = ST_RUN;
                else if (out_free) state_nxt = ST_PROG;
      ST_PROG:  if (!prog_en) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_RUN;
      inst_valid  <= 1'b0;
      inst_fault  <= FAULT_NONE;
      fetch_count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        inst_valid <= 1'b1;
        inst_fault <= fault_code(misaligned, out_of_range);
      end else if (inst_valid && inst_ready) begin
        inst_valid <= 1'b0;
      end
      if (accept && (fetch_count != 16'hFFFF)) begin
        fetch_count <= fetch_count + 16'd1;
      end
    end
  end

  inst_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (mem_we),
    .wr_addr (prog_addr),
    .wr_data (prog_data),
    .rd_en   (accept),
    .rd_addr (word_index[AW-1:0]),
    .rd_data (rd_data)
  );

  assign inst = (inst_fault != FAULT_NONE) ? NOP_WORD : rd_data;

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Randomized and directed bench for inst_mem_fetch against a transaction-level reference model.
module tb_inst_mem_fetch;
  import mips_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int M_RUN = 0, M_DRAIN = 1, M_PROG = 2;

  logic        clock;
  logic        reset_n;
  logic        prog_en, prog_we;
  logic [6:0]  prog_addr;
  logic [31:0] prog_data;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready, inst_valid, inst_ready;
  logic [31:0] inst;
  logic [1:0]  inst_fault;
  logic [15:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  inst_mem_fetch #(
    .DATA_W(32), .DEPTH(128), .ADDR_W(32), .NOP_WORD(NOP)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .prog_en(prog_en), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_fault(inst_fault), .fetch_count(fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory image, one pending result slot, mode and counter.
  logic [31:0] m_mem [128];
  bit          m_known [128];
  int          m_mode;
  bit          m_valid;
  logic [31:0] m_inst;
  logic [1:0]  m_fault;
  bit          m_inst_known;
  int          m_count;
  bit          m_acc, m_hs, m_empty_before;

  initial begin
    for (int i = 0; i < 128; i++) m_known[i] = 0;
  end

  function automatic bit model_ready();
    return reset_n && (m_mode == M_RUN) && (!m_valid || inst_ready);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_mode  = M_RUN;
      m_valid = 0;
      m_count = 0;
    end else begin
      m_acc          = model_ready() && fetch_req;
      m_hs           = m_valid && inst_ready;
      m_empty_before = !m_valid || m_hs;
      if (m_mode == M_PROG && prog_we) begin
        m_mem[prog_addr]   = prog_data;
        m_known[prog_addr] = 1;
      end
      if (m_acc) begin
        m_valid      = 1;
        m_fault      = {fetch_addr >= 32'd512, (fetch_addr % 4) != 0};
        m_inst_known = (m_fault != 2'b00) || m_known[fetch_addr[8:2]];
        m_inst       = (m_fault != 2'b00) ? NOP : m_mem[fetch_addr[8:2]];
        if (m_count < 65535) m_count++;
      end else if (m_hs) begin
        m_valid = 0;
      end
      case (m_mode)
        M_RUN:   if (prog_en) m_mode = (m_empty_before && !m_acc) ? M_PROG : M_DRAIN;
        M_DRAIN: if (!prog_en) m_mode = M_RUN; else if (m_empty_before) m_mode = M_PROG;
        default: if (!prog_en) m_mode = M_RUN;
      endcase
    end
  end

  always @(negedge clock) begin
    chk("fetch_ready", 32'(fetch_ready), 32'(model_ready()));
    chk("inst_valid", 32'(inst_valid), 32'(m_valid));
    chk("fetch_count", 32'(fetch_count), 32'(m_count));
    if (m_valid) begin
      chk("inst_fault", 32'(inst_fault), 32'(m_fault));
      if (m_inst_known) chk("inst", inst, m_inst);
    end
    if (!reset_n) begin
      chk("inst_in_reset", inst, 32'h0);
      chk("fault_in_reset", 32'(inst_fault), 32'h0);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    prog_en = 0; prog_we = 0; prog_addr = '0; prog_data = '0;
    fetch_req = 0; fetch_addr = '0; inst_ready = 1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, 32'(inst_valid), 32'h0);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_fault"}, 32'(inst_fault), 32'h0);
    chk({tag, "_count"}, 32'(fetch_count), 32'h0);
    chk({tag, "_ready"}, 32'(fetch_ready), 32'h0);
  endtask

  task automatic do_reset();
    reset_n = 0;
    #1;
    reset_checks("reset");
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1;
  endtask

  task automatic fetch_one(input logic [31:0] addr);
    fetch_req = 1; fetch_addr = addr; inst_ready = 1;
    cyc();
  endtask

  int prog_left;
  int r;

  initial begin
    reset_n = 0;
    idle_inputs();
    #3;
    reset_checks("init");
    do_reset();

    // Programming, then back-to-back fetches.
    prog_en = 1;
    cyc();
    prog_we = 1; prog_addr = 7'd0; prog_data = 32'h0022_1820;
    cyc();
    prog_addr = 7'd2; prog_data = 32'h8C24_0000;
    cyc();
    prog_we = 0; prog_en = 0;
    cyc();
    fetch_one(32'h0);
    chk("b2b_first", inst, 32'h0022_1820);
    chk("b2b_first_valid", 32'(inst_valid), 32'h1);
    fetch_one(32'h8);
    chk("b2b_second", inst, 32'h8C24_0000);
    chk("b2b_fault", 32'(inst_fault), 32'h0);
    fetch_req = 0;
    cyc();
    chk("b2b_count", 32'(fetch_count), 32'd2);

    // Stall for three cycles, then handshake with a same-cycle accept.
    fetch_req = 1; fetch_addr = 32'h0; inst_ready = 0;
    cyc();
    fetch_addr = 32'h8;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_valid", 32'(inst_valid), 32'h1);
      chk("stall_inst", inst, 32'h0022_1820);
      chk("stall_ready", 32'(fetch_ready), 32'h0);
    end
    inst_ready = 1;
    #1;
    chk("stall_release_ready", 32'(fetch_ready), 32'h1);
    cyc();
    chk("stall_next_inst", inst, 32'h8C24_0000);
    chk("stall_count", 32'(fetch_count), 32'd4);
    fetch_req = 0;
    cyc();

    // Fault codes, all counted.
    fetch_one(32'h2);
    chk("mis_fault", 32'(inst_fault), 32'h1);
    chk("mis_inst", inst, NOP);
    fetch_one(32'h200);
    chk("oor_fault", 32'(inst_fault), 32'h2);
    chk("oor_inst", inst, NOP);
    fetch_one(32'h202);
    chk("both_fault", 32'(inst_fault), 32'h3);
    chk("fault_count", 32'(fetch_count), 32'd7);
    fetch_req = 0;
    cyc();

    // DRAIN: pending result blocks programming writes.
    fetch_req = 1; fetch_addr = 32'h0; inst_ready = 0;
    cyc();
    fetch_req = 0; prog_en = 1; prog_we = 1; prog_addr = 7'd0; prog_data = 32'hFFFF_FFFF;
    cyc();
    chk("drain_state", 32'(dut.state), 32'(ST_DRAIN));
    cyc();
    chk("drain_hold_state", 32'(dut.state), 32'(ST_DRAIN));
    chk("drain_inst", inst, 32'h0022_1820);
    inst_ready = 1; prog_we = 0;
    cyc();
    chk("drain_to_prog", 32'(dut.state), 32'(ST_PROG));
    chk("prog_valid", 32'(inst_valid), 32'h0);
    prog_en = 0;
    cyc();
    chk("prog_to_run", 32'(dut.state), 32'(ST_RUN));
    fetch_one(32'h0);
    chk("drain_write_ignored", inst, 32'h0022_1820);
    fetch_req = 0;
    cyc();

    // Reset during a stall keeps memory.
    fetch_req = 1; fetch_addr = 32'h0; inst_ready = 0;
    cyc();
    fetch_req = 0;
    do_reset();
    fetch_one(32'h0);
    chk("post_reset_inst", inst, 32'h0022_1820);
    chk("post_reset_count", 32'(fetch_count), 32'd1);
    fetch_req = 0;
    cyc();

    // Fill memory with random words, then random traffic.
    prog_en = 1;
    cyc();
    for (int i = 0; i < 128; i++) begin
      prog_we = 1; prog_addr = 7'(i); prog_data = $urandom;
      cyc();
    end
    prog_we = 0; prog_en = 0;
    cyc();
    prog_left = 0;
    for (int c = 0; c < 3000; c++) begin
      fetch_req  = ($urandom_range(0, 3) != 0);
      inst_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r < 7)       fetch_addr = 32'($urandom_range(0, 127)) * 4;
      else if (r == 7) fetch_addr = $urandom;
      else if (r == 8) fetch_addr = 32'h200 + 32'($urandom_range(0, 255));
      else             fetch_addr = 32'($urandom_range(0, 511));
      if (prog_left > 0) prog_left--;
      else if ($urandom_range(0, 149) == 0) prog_left = $urandom_range(2, 8);
      prog_en   = (prog_left > 0);
      prog_we   = $urandom_range(0, 1) == 1;
      prog_addr = 7'($urandom_range(0, 127));
      prog_data = $urandom;
      cyc();
    end
    idle_inputs();
    cyc();

    // Counter saturation.
    do_reset();
    fetch_req = 1; fetch_addr = 32'h0; inst_ready = 1;
    repeat (65534) cyc();
    chk("sat_fffe", 32'(fetch_count), 32'hFFFE);
    cyc();
    chk("sat_ffff", 32'(fetch_count), 32'hFFFF);
    repeat (2) cyc();
    chk("sat_hold", 32'(fetch_count), 32'hFFFF);
    fetch_req = 0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
